signed_mac_pipe: RTL
====================

# signed_mac_pipe

Parametrised, pipelined signed multiplier / multiply-accumulate unit for the Reed-Solomon datapath, the generalised successor of the fixed 15x9 signed multiplier. It multiplies two two's-complement operands of configurable width through a configurable-depth pipeline with valid/ready flow control. Per sample, it can either pass the full-precision product or accumulate it into a wide running sum with overflow detection. It sits between the syndrome/locator arithmetic front end and the downstream consumers, replacing fixed-latency free-running multipliers.

## Interface
- A_WIDTH, 15, signed width of operand a (>= 2)
- B_WIDTH, 9, signed width of operand b (>= 2)
- STAGES, 3, pipeline depth in register stages (>= 1)
- ACC_WIDTH, 32, accumulator/result width (>= A_WIDTH+B_WIDTH)
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input sample present
- in_ready  out  1  input sample accepted this cycle when in_valid and in_ready are both high
- dataa  in  A_WIDTH  signed operand a
- datab  in  B_WIDTH  signed operand b
- in_mac  in  1  0: multiply only; 1: accumulate product
- in_first  in  1  with in_mac=1: restart the accumulator from this product (acc := 0 + p)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result when out_valid and out_ready are both high
- result  out  ACC_WIDTH  product or accumulated sum, signed
- overflow  out  1  sticky signed overflow of the current accumulation

## Operation
- Product p = dataa * datab, full precision (A_WIDTH+B_WIDTH bits signed), sign-extended to ACC_WIDTH. No truncation or rounding.
- Multiply mode (in_mac=0): result = sext(p); overflow = 0; the accumulator is unchanged.
- MAC mode (in_mac=1):
  - New value acc' = (in_first ? 0 : acc) + sext(p), wrapping modulo 2^ACC_WIDTH; result = acc'.
  - overflow' = (in_first ? 0 : overflow) | signed-add overflow (operands of equal sign, sum of opposite sign).
- Accumulator and overflow update only when a MAC-mode sample loads the final stage. This applies strictly in sample order; multiply-mode samples interleaved between MAC samples do not disturb the accumulator.
- Pipeline:
  - Stage 1 registers the operands and the mode bits.
  - The product is carried through stages 2..STAGES-1.
  - The accumulate add is performed into the final-stage register.
  - STAGES=1 collapses all of this into one register.
- Each stage holds a valid bit plus its payload.
- Flow control is a global stall: stall = out_valid & ~out_ready. in_ready = ~stall. While stalled, every stage, the accumulator and overflow hold.
- Bubbles are not compressed; a stage with valid=0 still advances when not stalled.
- Reset values: every stage valid = 0, out_valid = 0, result = 0, overflow = 0, accumulator = 0, in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight samples and the accumulator, with no output of partial results.
- in_mac=1 with no prior in_first after reset accumulates onto 0.
- in_first is ignored when in_mac=0.

## Timing
- Latency: a sample accepted at edge N appears with out_valid=1 after edge N+STAGES, in the absence of stalls. Each stall cycle adds one cycle.
- Throughput: one sample per cycle while out_ready=1.
- in_ready is combinational from out_valid/out_ready only. There is no combinational path from dataa/datab to any output.
- result/overflow are stable while out_valid=1 and out_ready=0.
- Simultaneous out_ready rising and in_valid in the same cycle: both transfers occur, and the pipeline advances by one.

## Structure
- Package signed_mac_pkg:
  - MODE_MUL/MODE_MAC constants.
  - Function prod_width(a,b)=a+b.
  - Function sadd_ovf(x,y,s) for signed overflow detection.
- Sub-module signed_mac_stage: one enable-gated valid+payload register (payload width parameter). It is instantiated in a generate loop for stages 1..STAGES-1. The final stage with the accumulator lives in the top level.

## Test plan
- Reset, then dataa=-16384, datab=-256, in_mac=0 -> after 3 cycles result=4194304, overflow=0, out_valid one cycle. Also dataa=16383, datab=255 -> 4177665; dataa=-16384, datab=255 -> -4177920.
- MAC: (3,4,first), (-5,2), (7,-1) back-to-back -> results 12, 2, -5 on consecutive cycles. Then a multiply-mode (2,2) -> 4, followed by MAC (1,1) -> -4.
- ACC_WIDTH=24 build: first=(-16384,-256), then repeat (-16384,-256) -> second result wraps to -8388608, overflow=1 sticky. A new in_first sample clears overflow.
- Backpressure: stream 8 samples, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, result held, all 8 results appear in order with none lost or duplicated, and the accumulator matches the reference sum.
- Reset asserted with 3 samples in flight and a nonzero accumulator -> next cycle out_valid=0, result=0, overflow=0. A following MAC sample (2,3) without in_first -> 6.
- Parameter sweep STAGES=1 and STAGES=5 with random operands and random out_ready -> latency equals STAGES, and results match the behavioural model.

Source files
------------

// File: rtl/signed_mac_pkg.sv
// Shared constants and helpers for the signed multiply / multiply-accumulate pipeline.
package signed_mac_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;

  function automatic int prod_width(input int a, input int b);
    return a + b;
  endfunction

  // x, y: sign bits of the two addends; s: sign bit of their wrapped sum
  function automatic logic sadd_ovf(input logic x, input logic y, input logic s);
    return (x == y) && (s != x);
  endfunction

endpackage

// File: rtl/signed_mac_stage.sv
// One pipeline register: valid bit plus payload, advancing only when enabled.
module signed_mac_stage #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/signed_mac_pipe.sv
// Pipelined signed multiplier with optional accumulate and sticky overflow.
// Valid/ready: a transfer happens on any edge where valid and ready are both high; the
// whole pipe stalls while out_valid & ~out_ready, and in_ready depends on nothing else.
module signed_mac_pipe
  import signed_mac_pkg::*;
#(
  parameter int A_WIDTH   = 15,
  parameter int B_WIDTH   = 9,
  parameter int STAGES    = 3,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   dataa,
  input  logic [B_WIDTH-1:0]   datab,
  input  logic                 in_mac,
  input  logic                 in_first,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);

  localparam int PW = prod_width(A_WIDTH, B_WIDTH);
  localparam int SW = PW + 2;

  // Payload is {mac, first, a, b} in stage 1 and {mac, first, product} afterwards;
  // both forms are SW bits wide, so every stage shares one register width.
  function automatic logic [SW-1:0] to_prod(input logic [SW-1:0] x);
    logic signed [PW-1:0] pa;
    logic signed [PW-1:0] pb;
    pa = PW'($signed(x[PW-1:B_WIDTH]));
    pb = PW'($signed(x[B_WIDTH-1:0]));
    return {x[SW-1:SW-2], pa * pb};
  endfunction

  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign adv      = ~stall;

  logic          vld [STAGES];
  logic [SW-1:0] pay [STAGES];

  assign vld[0] = in_valid;
  assign pay[0] = {in_mac, in_first & in_mac, dataa, datab};

  for (genvar i = 1; i < STAGES; i++) begin : g_stage
    logic [SW-1:0] d;
    if (i == 2) begin : g_mul
      assign d = to_prod(pay[1]);
    end else begin : g_pass
      assign d = pay[i-1];
    end
    signed_mac_stage #(.W(SW)) u_stage (
      .clock     (clock),
      .reset     (reset),
      .en        (adv),
      .in_valid  (vld[i-1]),
      .in_data   (d),
      .out_valid (vld[i]),
      .out_data  (pay[i])
    );
  end

  // Shallow pipes have no product stage, so the final stage multiplies itself.
  logic [SW-1:0] fp;
  if (STAGES <= 2) begin : g_fsrc_mul
    assign fp = to_prod(pay[STAGES-1]);
  end else begin : g_fsrc_pass
    assign fp = pay[STAGES-1];
  end

  logic                        fv;
  logic                        f_mac;
  logic                        f_first;
  logic signed [ACC_WIDTH-1:0] pe;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] sum;
  logic        [ACC_WIDTH-1:0] acc;
  logic                        acc_ovf;
  logic                        new_ovf;

  assign fv = vld[STAGES-1];

  always_comb begin
    f_mac   = fp[SW-1];
    f_first = fp[SW-2];
    pe      = ACC_WIDTH'($signed(fp[PW-1:0]));
    base    = f_first ? '0 : acc;
    sum     = base + pe;
    new_ovf = (f_first ? 1'b0 : acc_ovf)
            | sadd_ovf(base[ACC_WIDTH-1], pe[ACC_WIDTH-1], sum[ACC_WIDTH-1]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= fv;
      if (fv) begin
        if (f_mac == MODE_MAC) begin
          result   <= sum;
          overflow <= new_ovf;
          acc      <= sum;
          acc_ovf  <= new_ovf;
        end else begin
          result   <= pe;
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule
